elevator_car: RTL and testbench
===============================

# elevator_car

Single-car elevator controller that consumes the per-floor hall-call vectors produced by `updown` (`up_passenger`, `down_passenger`) plus in-car destination buttons. It schedules the car collectively (SCAN): it moves floor by floor, stops to serve matching calls, times the door, and reverses only when no calls remain ahead. It reports car position, direction and door state, and pulses per-floor service strobes so upstream logic can retire the served calls.

## Interface
- `FLOORS`, 7, number of floors; floor index 0..FLOORS-1, bit i of every vector = floor i.
- `MOVE_CYCLES`, 4, clock cycles to travel one floor (≥1).
- `DOOR_CYCLES`, 3, cycles the door stays open per service (≥1).

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `up_passenger` in 7: level hall-call up requests; bit FLOORS-1 ignored.
- `down_passenger` in 7: level hall-call down requests; bit 0 ignored.
- `car_call` in 7: level in-car destination requests.
- `curr_floor` out 3: current floor.
- `dir_elevator` out 2: 00 idle, 01 up, 10 down (11 never driven).
- `door_open` out 1: door open.
- `serve_up`, `serve_down`, `serve_car` out 7 each: one-cycle strobes, bit f = call at floor f served.
- `door_hold` in 1: present only with `ELEVATOR_DOOR_HOLD_EN`.

## Operation
- Request latches `up_req`, `down_req`, `car_req` (7 bits each): every edge `req <= (req | masked input) & ~clear`. Clear wins over a same-cycle set; a still-asserted input re-latches on the next edge.
- "Ahead" = any latched request at a floor strictly beyond `curr_floor` in the current direction; "behind" likewise in the opposite direction.
- States: IDLE, MOVE, DOOR.
- IDLE (dir 00, door closed): request of any type at `curr_floor` → DOOR, clear all three bits at that floor. Else requests above → dir 01, MOVE. Else requests below → dir 10, MOVE. Up wins when both exist.
- MOVE: counter runs MOVE_CYCLES; on terminal count `curr_floor` ±1 and the stop test runs on the new floor f.
  - Up: stop if `car_req[f]` or `up_req[f]`, or if `down_req[f]` with nothing ahead. Down is symmetric.
  - Stop → DOOR. Clear `car_req[f]` and the same-direction hall bit. Clear the opposite hall bit only if nothing is ahead (dir flips on this stop).
  - No stop and requests ahead → remain in MOVE and restart the counter. Nothing anywhere → IDLE.
- DOOR: `door_open`=1 for DOOR_CYCLES cycles. On expiry, checks in priority order:
  - Latched request at `curr_floor` matching dir (any type if dir flipped to idle) → re-serve, restart the door timer.
  - Else requests ahead → MOVE.
  - Else requests behind → flip dir, MOVE.
  - Else → IDLE, dir 00.
- `curr_floor` never leaves 0..FLOORS-1. The top and bottom floors always stop, because the stop test sees nothing ahead.

## Timing
- Reset: `curr_floor`=0, `dir_elevator`=00, `door_open`=0, all serve strobes 0, all latches 0, counters 0, state IDLE. Reset mid-MOVE or mid-DOOR takes effect on that edge with no completion of the floor or door.
- All outputs are registered.
- Input sampled at edge N → latched at N → state decision at N+1.
- From IDLE, dir and MOVE are asserted at N+1. Floor k is reached at N+1+k·MOVE_CYCLES.
- `door_open`, serve strobes and the new `curr_floor` update on the same edge. Strobes last exactly 1 cycle.
- The door closes after DOOR_CYCLES cycles. The next state (MOVE/IDLE) is taken on that same edge.
- Serve strobes are asserted only for bits that were latched at the time of clearing.

## Configuration
- `ELEVATOR_DOOR_HOLD_EN` defined:
  - Adds the `door_hold` input.
  - While `door_hold`=1 in DOOR, the door timer reloads to DOOR_CYCLES.
  - The door closes DOOR_CYCLES cycles after `door_hold` falls.
- Undefined: no port; the door timer is fixed.

## Test plan
- Reset: hold `reset` 2 cycles mid-MOVE at floor 2 → next cycle `curr_floor`=0, dir 00, `door_open`=0, all strobes 0; previously latched calls are not served.
- Simple up call: idle at 0, pulse `up_passenger`=7'b0001000 one cycle → dir 01, floors 1,2,3 at 4-cycle spacing, `serve_up`=7'b0001000 for 1 cycle, `door_open` 3 cycles, then dir 00.
- Collective stop: idle at 0; `car_call`=7'b0100000, `up_passenger`=7'b0000100, `down_passenger`=7'b0010000.
  - Stops at floor 2 with `serve_up[2]`; passes floor 4.
  - Stops at floor 5 with `serve_car[5]`.
  - Reverses, stops at floor 4 with `serve_down[4]`, then goes idle.
- Same-floor call: idle at 3, `car_call[3]`=1 → door opens 2 edges later, `serve_car`=7'b0001000, `curr_floor` stays 3.
- Opposite call during travel: moving up 0→6 on `car_call[6]`, `down_passenger[1]` raised at floor 3 → no stop at 1 on the way up; served after reversal at 6; dir never 11.
- Macro on: in DOOR, hold `door_hold`=1 for 10 cycles → `door_open` stays high; it falls 3 cycles after release.

Source files
------------

// File: rtl/elevator_car.sv
// Single-car collective (SCAN) elevator controller: call latches, floor travel timer, door timer, serve strobes.
// Optional ELEVATOR_DOOR_HOLD_EN adds a door_hold input that keeps the door open while asserted.
module elevator_car #(
   parameter int FLOORS      = 7,
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 3,
   localparam int FLOOR_W    = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  up_passenger,
   input  logic [FLOORS-1:0]  down_passenger,
   input  logic [FLOORS-1:0]  car_call,
`ifdef ELEVATOR_DOOR_HOLD_EN
   input  logic               door_hold,
`endif
   output logic [FLOOR_W-1:0] curr_floor,
   output logic [1:0]         dir_elevator,
   output logic               door_open,
   output logic [FLOORS-1:0]  serve_up,
   output logic [FLOORS-1:0]  serve_down,
   output logic [FLOORS-1:0]  serve_car
);

   localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);
   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DN   = 2'b10;
   localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [FLOOR_W-1:0]  floor_d, next_floor, tgt_floor;
   logic [1:0]          dir_d, turn_dir, served_dir;
   logic [FLOORS-1:0]   up_req, down_req, car_req, all_req;
   logic [FLOORS-1:0]   same_req, opp_req, tgt_oh;
   logic [FLOORS-1:0]   clr_up, clr_dn, clr_car;
   logic [FLOORS-1:0]   serve_up_d, serve_down_d, serve_car_d;
   logic                going_up, ahead_up, ahead_dn, ahead, behind;
   logic                hit_same, hit_opp, do_serve, serve_all, hold, door_d;

   function automatic logic [FLOORS-1:0] above_of(input logic [FLOOR_W-1:0] f);
      return {FLOORS{1'b1}} << (int'(f) + 1);
   endfunction

   function automatic logic [FLOORS-1:0] below_of(input logic [FLOOR_W-1:0] f);
      return ~({FLOORS{1'b1}} << f);
   endfunction

   function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
      return {{(FLOORS-1){1'b0}}, 1'b1} << f;
   endfunction

   // Decisions are taken about the floor being arrived at (MOVE) or the floor the car sits at.
   always_comb begin
      all_req    = up_req | down_req | car_req;
      going_up   = (dir_elevator == DIR_UP);
      next_floor = going_up ? (curr_floor + FLOOR_W'(1)) : (curr_floor - FLOOR_W'(1));
      tgt_floor  = (state == S_MOVE) ? next_floor : curr_floor;
      tgt_oh     = onehot(tgt_floor);
      ahead_up   = |(all_req & above_of(tgt_floor));
      ahead_dn   = |(all_req & below_of(tgt_floor));
      ahead      = going_up ? ahead_up : ahead_dn;
      behind     = going_up ? ahead_dn : ahead_up;
      same_req   = going_up ? up_req : down_req;
      opp_req    = going_up ? down_req : up_req;
      hit_same   = |((car_req | same_req) & tgt_oh);
      hit_opp    = |(opp_req & tgt_oh);
      turn_dir   = behind ? (going_up ? DIR_DN : DIR_UP) : DIR_IDLE;
      served_dir = ahead ? dir_elevator : turn_dir;
   end

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      floor_d   = curr_floor;
      dir_d     = dir_elevator;
      do_serve  = 1'b0;
      serve_all = 1'b0;
      clr_up    = '0;
      clr_dn    = '0;
      clr_car   = '0;
      hold      = 1'b0;
`ifdef ELEVATOR_DOOR_HOLD_EN
      hold      = door_hold;
`endif
      unique case (state)
         S_IDLE: begin
            if (|(all_req & tgt_oh)) begin
               serve_all = 1'b1;
               state_d   = S_DOOR;
               cnt_d     = '0;
            end else if (ahead_up) begin
               dir_d   = DIR_UP;
               state_d = S_MOVE;
               cnt_d   = '0;
            end else if (ahead_dn) begin
               dir_d   = DIR_DN;
               state_d = S_MOVE;
               cnt_d   = '0;
            end
         end
         S_MOVE: begin
            if (cnt == MOVE_LAST) begin
               floor_d = next_floor;
               cnt_d   = '0;
               if (hit_same || (hit_opp && !ahead)) begin
                  do_serve = 1'b1;
                  state_d  = S_DOOR;
               end else if (!ahead) begin
                  state_d = S_IDLE;
                  dir_d   = DIR_IDLE;
               end
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_DOOR: begin
            if (hold) begin
               cnt_d = '0;
            end else if (cnt == DOOR_LAST) begin
               cnt_d = '0;
               if (dir_elevator == DIR_IDLE) begin
                  if (|(all_req & tgt_oh)) begin
                     serve_all = 1'b1;
                  end else if (ahead_up) begin
                     dir_d   = DIR_UP;
                     state_d = S_MOVE;
                  end else if (ahead_dn) begin
                     dir_d   = DIR_DN;
                     state_d = S_MOVE;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else if (hit_same) begin
                  do_serve = 1'b1;
               end else if (ahead) begin
                  state_d = S_MOVE;
               end else if (behind) begin
                  dir_d   = going_up ? DIR_DN : DIR_UP;
                  state_d = S_MOVE;
               end else begin
                  dir_d   = DIR_IDLE;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The opposite hall call is only taken when the car turns around at this floor.
      if (serve_all) begin
         clr_up  = tgt_oh;
         clr_dn  = tgt_oh;
         clr_car = tgt_oh;
      end else if (do_serve) begin
         clr_car = tgt_oh;
         dir_d   = served_dir;
         if (going_up) begin
            clr_up = tgt_oh;
            clr_dn = ahead ? '0 : tgt_oh;
         end else begin
            clr_dn = tgt_oh;
            clr_up = ahead ? '0 : tgt_oh;
         end
      end
   end

   always_comb begin
      door_d       = (state_d == S_DOOR);
      serve_up_d   = up_req & clr_up;
      serve_down_d = down_req & clr_dn;
      serve_car_d  = car_req & clr_car;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         curr_floor   <= '0;
         dir_elevator <= DIR_IDLE;
         door_open    <= 1'b0;
         serve_up     <= '0;
         serve_down   <= '0;
         serve_car    <= '0;
         up_req       <= '0;
         down_req     <= '0;
         car_req      <= '0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         curr_floor   <= floor_d;
         dir_elevator <= dir_d;
         door_open    <= door_d;
         serve_up     <= serve_up_d;
         serve_down   <= serve_down_d;
         serve_car    <= serve_car_d;
         up_req       <= (up_req | (up_passenger & UP_MASK)) & ~clr_up;
         down_req     <= (down_req | (down_passenger & DN_MASK)) & ~clr_dn;
         car_req      <= (car_req | car_call) & ~clr_car;
      end
   end

endmodule

// File: tb/tb_elevator_car.sv
// Directed bench for elevator_car: reset, single call, collective stops, same-floor call,
// reversal for an opposite call, and door hold when ELEVATOR_DOOR_HOLD_EN is defined.
module tb_elevator_car;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] up_passenger, down_passenger, car_call;
   logic       door_hold;
   logic [2:0] curr_floor;
   logic [1:0] dir_elevator;
   logic       door_open;
   logic [6:0] serve_up, serve_down, serve_car;

   int checks = 0;
   int errors = 0;

   elevator_car #(.FLOORS(7), .MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .up_passenger   (up_passenger),
      .down_passenger (down_passenger),
      .car_call       (car_call),
`ifdef ELEVATOR_DOOR_HOLD_EN
      .door_hold      (door_hold),
`endif
      .curr_floor     (curr_floor),
      .dir_elevator   (dir_elevator),
      .door_open      (door_open),
      .serve_up       (serve_up),
      .serve_down     (serve_down),
      .serve_car      (serve_car)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      up_passenger = '0;
      down_passenger = '0;
      car_call = '0;
      door_hold = 1'b0;
      tick(2);
      reset = 1'b0;
      chk("rst_floor", 32'(curr_floor), 0);
      chk("rst_dir", 32'(dir_elevator), 0);
      chk("rst_door", 32'(door_open), 0);
      chk("rst_serve", 32'({serve_up, serve_down, serve_car}), 0);

      // Single up call at floor 3
      up_passenger = 7'b0001000;
      tick(1);
      up_passenger = '0;
      tick(1);
      chk("up_dir", 32'(dir_elevator), 32'h1);
      chk("up_floor_start", 32'(curr_floor), 0);
      tick(3);
      chk("up_floor0_hold", 32'(curr_floor), 0);
      tick(1);
      chk("up_floor1", 32'(curr_floor), 1);
      tick(4);
      chk("up_floor2", 32'(curr_floor), 2);
      chk("up_door_closed", 32'(door_open), 0);
      tick(4);
      chk("up_floor3", 32'(curr_floor), 3);
      chk("up_serve", 32'(serve_up), 32'b0001000);
      chk("up_door_open", 32'(door_open), 1);
      tick(1);
      chk("up_serve_pulse", 32'(serve_up), 0);
      chk("up_door_c2", 32'(door_open), 1);
      tick(1);
      chk("up_door_c3", 32'(door_open), 1);
      tick(1);
      chk("up_door_shut", 32'(door_open), 0);
      chk("up_dir_idle", 32'(dir_elevator), 0);
      chk("up_floor_final", 32'(curr_floor), 3);

      // Car call at the floor the car already sits on
      car_call = 7'b0001000;
      tick(1);
      car_call = '0;
      chk("sf_door_early", 32'(door_open), 0);
      tick(1);
      chk("sf_door", 32'(door_open), 1);
      chk("sf_serve", 32'(serve_car), 32'b0001000);
      chk("sf_floor", 32'(curr_floor), 3);
      tick(2);
      chk("sf_door_c3", 32'(door_open), 1);
      tick(1);
      chk("sf_door_shut", 32'(door_open), 0);
      chk("sf_dir", 32'(dir_elevator), 0);

      // Reset while travelling down through floor 2
      car_call = 7'b0000001;
      tick(1);
      car_call = '0;
      tick(1);
      chk("rm_dir_down", 32'(dir_elevator), 32'h2);
      tick(4);
      chk("rm_floor2", 32'(curr_floor), 2);
      tick(1);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      chk("rm_floor", 32'(curr_floor), 0);
      chk("rm_dir", 32'(dir_elevator), 0);
      chk("rm_door", 32'(door_open), 0);
      chk("rm_serve", 32'({serve_up, serve_down, serve_car}), 0);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("rm_no_service", 32'({door_open, dir_elevator, serve_car}), 0);
      end

      // Collective scheduling: car 5, up 2, down 4
      car_call = 7'b0100000;
      up_passenger = 7'b0000100;
      down_passenger = 7'b0010000;
      tick(1);
      car_call = '0;
      up_passenger = '0;
      down_passenger = '0;
      tick(1);
      chk("col_dir_up", 32'(dir_elevator), 32'h1);
      tick(8);
      chk("col_floor2", 32'(curr_floor), 2);
      chk("col_serve_up2", 32'(serve_up), 32'b0000100);
      chk("col_door2", 32'(door_open), 1);
      tick(1);
      chk("col_serve_up_pulse", 32'(serve_up), 0);
      tick(2);
      chk("col_door2_shut", 32'(door_open), 0);
      chk("col_dir_still_up", 32'(dir_elevator), 32'h1);
      tick(8);
      chk("col_pass4_floor", 32'(curr_floor), 4);
      chk("col_pass4_door", 32'(door_open), 0);
      chk("col_pass4_serve", 32'(serve_down), 0);
      tick(4);
      chk("col_floor5", 32'(curr_floor), 5);
      chk("col_serve_car5", 32'(serve_car), 32'b0100000);
      chk("col_door5", 32'(door_open), 1);
      tick(7);
      chk("col_floor4", 32'(curr_floor), 4);
      chk("col_serve_down4", 32'(serve_down), 32'b0010000);
      chk("col_door4", 32'(door_open), 1);
      tick(3);
      chk("col_end_door", 32'(door_open), 0);
      chk("col_end_dir", 32'(dir_elevator), 0);
      chk("col_end_floor", 32'(curr_floor), 4);

      // Down call at floor 1 raised while heading up to 6
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      car_call = 7'b1000000;
      tick(1);
      car_call = '0;
      tick(1);
      chk("op_dir_up", 32'(dir_elevator), 32'h1);
      for (int i = 3; i <= 49; i++) begin
         tick(1);
         chk("op_dir_legal", 32'(dir_elevator == 2'b11), 0);
         if (i == 6) begin
            chk("op_floor1_up", 32'(curr_floor), 1);
            chk("op_no_stop1", 32'({door_open, serve_down}), 0);
         end
         if (i == 14) begin
            chk("op_floor3", 32'(curr_floor), 3);
            down_passenger = 7'b0000010;
         end
         if (i == 15) down_passenger = '0;
         if (i == 26) begin
            chk("op_floor6", 32'(curr_floor), 6);
            chk("op_serve_car6", 32'(serve_car), 32'b1000000);
            chk("op_door6", 32'(door_open), 1);
         end
         if (i == 29) begin
            chk("op_door6_shut", 32'(door_open), 0);
            chk("op_dir_down", 32'(dir_elevator), 32'h2);
         end
         if (i == 49) begin
            chk("op_floor1_down", 32'(curr_floor), 1);
            chk("op_serve_down1", 32'(serve_down), 32'b0000010);
            chk("op_door1", 32'(door_open), 1);
         end
      end

`ifdef ELEVATOR_DOOR_HOLD_EN
      door_hold = 1'b1;
      tick(5);
      chk("hold_mid", 32'(door_open), 1);
      tick(5);
      door_hold = 1'b0;
      chk("hold_end", 32'(door_open), 1);
      tick(2);
      chk("hold_release_c2", 32'(door_open), 1);
      tick(1);
      chk("hold_release_shut", 32'(door_open), 0);
`else
      tick(2);
      chk("door1_c3", 32'(door_open), 1);
      tick(1);
      chk("door1_shut", 32'(door_open), 0);
`endif
      chk("final_dir", 32'(dir_elevator), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
